// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small input FIFO.
// Words enter over a valid/ready handshake. Each word is sent as:
// start, data (LSB first), optional parity, then stop bit(s).
// The line outputs are registered from the current FSM state, so the
// line trails the state by one clock. This gives one cycle between a push
// into an idle, empty block and the start bit. Back-to-back frames still
// have no gap, because the next word is popped on the final STOP cycle.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 279,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          tx
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

  // Refuse to elaborate with a parameter set the datapath was not sized for.
  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_fifo: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         clk_cnt_reg, clk_cnt_next;
  logic [3:0]            bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  parity_reg;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  shift_en;
  logic                  last_clk;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0]       count_reg;
  logic                  push, pop;

  assign tx_ready   = (count_reg != DEPTH_C);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_reg;
  assign last_clk   = (clk_cnt_reg == CLK_LAST);
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

  // FIFO storage: write port only, so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap for free (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Frame datapath: the word and its parity are captured at pop (registered
  // RAM read). The word then shifts right once per data bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg  <= mem[rd_ptr_reg];
      parity_reg <= (^mem[rd_ptr_reg]) ^ (PARITY == 2);
    end else if (shift_en) begin
      shift_reg  <= shift_reg >> 1;
    end
  end

  // State register and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Next state, bit timing and the line value for the current state.
  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = last_clk ? '0 : clk_cnt_reg + CW'(1);
    bit_cnt_next = bit_cnt_reg;
    tx_next      = 1'b1;
    busy_next    = 1'b1;
    done_next    = 1'b0;
    shift_en     = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy_next    = 1'b0;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        tx_next = 1'b0;
        if (last_clk) state_next = S_DATA;
      end
      S_DATA: begin
        tx_next = shift_reg[0];
        if (last_clk) begin
          shift_en = 1'b1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      S_PARITY: begin
        tx_next = parity_reg;
        if (last_clk) state_next = S_STOP;
      end
      S_STOP: begin
        if (last_clk) begin
          if (bit_cnt_reg == STOP_LAST) begin
            done_next    = 1'b1;
            bit_cnt_next = '0;
            // Chain straight into the next frame when a word is waiting.
            if (count_reg != '0) begin
              pop        = 1'b1;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations run side by side.
// The configurations are 8N1, 7E1, 7O1 and 8N2, each with CLKS_PER_BIT=4.
// Each one keeps a queue-based reference of the expected line waveform.
// That reference is compared every cycle, and hand-computed frames pin it.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] n_cmp = 0;
  logic [31:0] n_bad = 0;

  task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cfg%0d t=%0t: got %0h, required %0h", nm, cfg, $time, act, exp);
    end
  endtask

  function automatic int cfg_db(int i);
    case (i) 1, 2: return 7; default: return 8; endcase
  endfunction
  function automatic int cfg_par(int i);
    case (i) 1: return 1; 2: return 2; default: return 0; endcase
  endfunction
  function automatic int cfg_sb(int i);
    case (i) 3: return 2; default: return 1; endcase
  endfunction
  function automatic int cfg_word(int i);
    case (i) 0: return 'hA5; 3: return 'hFF; default: return 'h53; endcase
  endfunction
  // Hand-written frames, bit 0 = start bit, one entry per bit period.
  function automatic logic [10:0] cfg_lit(int i);
    case (i)
      0:       return {2'b01, 8'hA5, 1'b0};
      1:       return {1'b0, 1'b1, 1'b0, 7'h53, 1'b0};
      2:       return {1'b0, 1'b1, 1'b1, 7'h53, 1'b0};
      default: return {1'b1, 1'b1, 8'hFF, 1'b0};
    endcase
  endfunction
  function automatic int cfg_nb(int i);
    case (i) 3: return 11; default: return 10; endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int DB  = cfg_db(gi);
    localparam int PAR = cfg_par(gi);
    localparam int SB  = cfg_sb(gi);
    localparam int NB  = cfg_nb(gi);

    logic          rst, vld, rdy, busy, done, tx;
    logic [DB-1:0] dat;
    logic [2:0]    cnt;
    logic          fin = 1'b0;

    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR),
      .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
      .clk(clk), .rst(rst), .tx_data(dat), .tx_valid(vld), .tx_ready(rdy),
      .fifo_count(cnt), .busy(busy), .frame_done(done), .tx(tx)
    );

    // Reference: accepted words wait in wq. When the line has nothing left
    // to show, the head word is expanded into per-cycle line samples.
    logic [DB-1:0] wq [$];
    logic [1:0]    lineq [$];   // {last cycle of frame, line value}
    logic          m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, started = 1'b0;
    int            m_cnt = 0;

    always @(posedge clk) begin : model
      logic [1:0]    e;
      logic [DB-1:0] w;
      logic [11:0]   fb;
      int            nb, n0;
      started <= 1'b1;
      if (rst) begin
        wq.delete();
        lineq.delete();
        m_tx <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      end else begin
        n0 = wq.size();
        if (lineq.size() != 0) begin
          e = lineq.pop_front();
          m_tx <= e[0]; m_busy <= 1'b1; m_done <= e[1];
        end else begin
          m_tx <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
        end
        if (lineq.size() == 0 && wq.size() != 0) begin
          w = wq.pop_front();
          fb = '0; nb = 0;
          fb[nb] = 1'b0; nb++;
          for (int b = 0; b < DB; b++) begin fb[nb] = w[b]; nb++; end
          if (PAR != 0) begin fb[nb] = (^w) ^ (PAR == 2); nb++; end
          for (int s = 0; s < SB; s++) begin fb[nb] = 1'b1; nb++; end
          for (int i = 0; i < nb; i++)
            for (int c = 0; c < CPB; c++)
              lineq.push_back({(i == nb - 1) && (c == CPB - 1), fb[i]});
        end
        if (vld && n0 != DEPTH) wq.push_back(dat);
        m_cnt <= wq.size();
      end
    end

    // Every-cycle comparison against the reference, away from the edge.
    always @(negedge clk) begin
      if (started) begin
        chk("tx", gi, 32'(tx), 32'(m_tx));
        chk("busy", gi, 32'(busy), 32'(m_busy));
        chk("frame_done", gi, 32'(done), 32'(m_done));
        chk("fifo_count", gi, 32'(cnt), 32'(m_cnt));
        chk("tx_ready", gi, 32'(rdy), 32'(m_cnt != DEPTH));
      end
    end

    initial begin : stim
      int ones, dn, dpos, guard, saw_full;
      logic acc;
      logic [10:0] lit;
      lit = cfg_lit(gi);
      rst = 1'b1; vld = 1'b0; dat = '0;
      repeat (2) @(posedge clk);
      #1 vld = 1'b1; dat = '1;
      @(posedge clk); #1 vld = 1'b0;
      @(negedge clk);
      chk("rst_tx", gi, 32'(tx), 32'd1);
      chk("rst_ready", gi, 32'(rdy), 32'd1);
      chk("rst_busy", gi, 32'(busy), 32'd0);
      chk("rst_count", gi, 32'(cnt), 32'd0);
      chk("rst_done", gi, 32'(done), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Single frame against a hand-written bit pattern.
      @(posedge clk); #1 vld = 1'b1; dat = DB'(cfg_word(gi));
      @(posedge clk); #1 vld = 1'b0;
      ones = 0; dn = 0; dpos = -1;
      for (int c = 0; c < NB * CPB + 4; c++) begin
        @(negedge clk);
        if (c >= 2 && (c - 2) % CPB == 1 && (c - 2) / CPB < NB)
          chk("lit_bit", gi, 32'(tx), 32'(lit[(c - 2) / CPB]));
        if (busy) ones++;
        if (done) begin dn++; dpos = c; end
      end
      chk("lit_busy_cycles", gi, 32'(ones), 32'(NB * CPB));
      chk("lit_done_count", gi, 32'(dn), 32'd1);
      chk("lit_done_pos", gi, 32'(dpos), 32'(NB * CPB + 1));

      // Sender holds 1..6 until accepted; the FIFO must fill up.
      saw_full = 0;
      @(posedge clk); #1;
      for (int k = 1; k <= 6; k++) begin
        dat = DB'(k); vld = 1'b1; guard = 0;
        do begin
          @(negedge clk); acc = rdy;
          if (cnt == 3'd4) saw_full = 1;
          @(posedge clk); #1; guard++;
        end while (!acc && guard < 400);
        if (!acc) chk("fill_timeout", gi, 32'd0, 32'd1);
      end
      vld = 1'b0;
      chk("fill_reached_full", gi, 32'(saw_full), 32'd1);
      guard = 0;
      while ((wq.size() != 0 || lineq.size() != 0) && guard < 3000) begin @(posedge clk); guard++; end
      if (guard >= 3000) chk("drain_timeout", gi, 32'd0, 32'd1);

      // Reset during data bit 3 of 0x3C with two words queued behind it.
      @(posedge clk); #1 vld = 1'b1; dat = DB'(8'h3C);
      @(posedge clk); #1 dat = DB'(8'h11);
      @(posedge clk); #1 dat = DB'(8'h22);
      @(posedge clk); #1 vld = 1'b0;
      repeat (4 * CPB - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_tx", gi, 32'(tx), 32'd1);
      chk("midrst_count", gi, 32'(cnt), 32'd0);
      chk("midrst_done", gi, 32'(done), 32'd0);
      @(posedge clk); #1 vld = 1'b1; dat = DB'(8'h81);
      @(posedge clk); #1 vld = 1'b0;
      guard = 0;
      while ((wq.size() != 0 || lineq.size() != 0) && guard < 3000) begin @(posedge clk); guard++; end
      if (guard >= 3000) chk("drain_timeout", gi, 32'd0, 32'd1);

      // Random traffic, sometimes keeping the FIFO full.
      for (int c = 0; c < 700; c++) begin
        @(posedge clk); #1;
        vld = ($urandom_range(0, 2) == 0);
        dat = DB'($urandom);
      end
      @(posedge clk); #1 vld = 1'b0;
      guard = 0;
      while ((wq.size() != 0 || lineq.size() != 0) && guard < 3000) begin @(posedge clk); guard++; end
      if (guard >= 3000) chk("drain_timeout", gi, 32'd0, 32'd1);
      repeat (3) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && i < 60000) begin
      @(posedge clk);
      i++;
    end
    if (i >= 60000) chk("global_timeout", -1, 32'd0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
